mac_pipeline: RTL and testbench

Parametrised, pipelined multiply-add / multiply-accumulate unit; successor of the fixed 8-bit A*B+C register stage used in Zadanie_2. Computes A*B+C at full precision, with an optional running-accumulate mode, a valid qualifier, selectable signed/unsigned arithmetic and saturation. Sits between the sample source and downstream filtering or readout logic. Throughput is one sample per clock, with no backpressure.

---
 rtl/mac_pipeline_if.sv | 26 ++
 rtl/mac_pipeline.sv | 112 +++++++++++
 tb/tb_mac_pipeline.sv | 196 +++++++++++++++++++
 3 files changed

// File: rtl/mac_pipeline_if.sv
// Sample/result bundle for mac_pipeline: operands and controls towards the MAC,
// result, valid and saturation flag back from it.
interface mac_pipeline_if #(
   parameter int WIDTH     = 8,
   parameter int OUT_WIDTH = 20
);
   logic                 in_valid;
   logic                 mode;
   logic                 clr_acc;
   logic [WIDTH-1:0]     a;
   logic [WIDTH-1:0]     b;
   logic [WIDTH-1:0]     c;
   logic                 out_valid;
   logic [OUT_WIDTH-1:0] data_out;
   logic                 ovf;

   modport master (
      output in_valid, mode, clr_acc, a, b, c,
      input  out_valid, data_out, ovf
   );

   modport slave (
      input  in_valid, mode, clr_acc, a, b, c,
      output out_valid, data_out, ovf
   );
endinterface

// File: rtl/mac_pipeline.sv
// Two-stage A*B+C unit with optional saturating running accumulate,
// selectable signed/unsigned arithmetic, one sample per clock.
module mac_pipeline #(
   parameter int WIDTH     = 8,
   parameter int OUT_WIDTH = 20,
   parameter int SIGNED    = 0
) (
   input  logic          clk,
   input  logic          rst,
   mac_pipeline_if.slave bus
);

   localparam int PW   = 2 * WIDTH;
   localparam int SW   = OUT_WIDTH + 2;
   localparam bit FILL = (SIGNED != 0);

   generate
      if (OUT_WIDTH < 2 * WIDTH + 1) begin : g_width_check
         $error("mac_pipeline: OUT_WIDTH must be at least 2*WIDTH+1");
      end
   endgenerate

   // Operands are extended to full product width first, so one unsigned
   // multiplier yields the correct low 2*WIDTH bits for either signedness.
   logic [PW-1:0]        a_x;
   logic [PW-1:0]        b_x;
   logic [PW-1:0]        prod;
   logic [OUT_WIDTH-1:0] c_x;

   assign a_x  = {{WIDTH{FILL & bus.a[WIDTH-1]}}, bus.a};
   assign b_x  = {{WIDTH{FILL & bus.b[WIDTH-1]}}, bus.b};
   assign prod = a_x * b_x;
   assign c_x  = {{(OUT_WIDTH-WIDTH){FILL & bus.c[WIDTH-1]}}, bus.c};

   logic                 valid_s1;
   logic                 mode_s1;
   logic                 clr_s1;
   logic [PW-1:0]        p_s1;
   logic [OUT_WIDTH-1:0] c_s1;

   // NOTE: registers use non-blocking assignments so every stage samples the
   // pre-edge value of the one before it, independent of statement order.
   always_ff @(posedge clk) begin
      if (rst) begin
         valid_s1 <= 1'b0;
         mode_s1  <= 1'b0;
         clr_s1   <= 1'b0;
         p_s1     <= '0;
         c_s1     <= '0;
      end else begin
         valid_s1 <= bus.in_valid;
         mode_s1  <= bus.mode;
         clr_s1   <= bus.clr_acc;
         p_s1     <= prod;
         c_s1     <= c_x;
      end
   end

   logic [OUT_WIDTH-1:0] acc;
   logic [SW-1:0]        acc_x;
   logic [SW-1:0]        p_x;
   logic [SW-1:0]        c_sx;
   logic [SW-1:0]        base;
   logic [SW-1:0]        sum;
   logic [OUT_WIDTH-1:0] result;
   logic                 sat;

   assign acc_x = {{2{FILL & acc[OUT_WIDTH-1]}}, acc};
   assign p_x   = {{(SW-PW){FILL & p_s1[PW-1]}}, p_s1};
   assign c_sx  = {{2{FILL & c_s1[OUT_WIDTH-1]}}, c_s1};

   // Two guard bits hold any ACC+P+C exactly, so range checks are simple
   // tests on the bits above the result width.
   // NOTE: every always_comb output gets a default first, so no path can
   // leave a value unassigned and infer a latch.
   always_comb begin
      base   = (mode_s1 && !clr_s1) ? acc_x : '0;
      sum    = base + p_x + c_sx;
      result = sum[OUT_WIDTH-1:0];
      sat    = 1'b0;
      if (mode_s1) begin
         if (FILL) begin
            if (sum[SW-1:OUT_WIDTH-1] != {3{sum[SW-1]}}) begin
               sat    = 1'b1;
               result = {sum[SW-1], {(OUT_WIDTH-1){~sum[SW-1]}}};
            end
         end else if (sum[SW-1:OUT_WIDTH] != 2'b00) begin
            sat    = 1'b1;
            result = '1;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         bus.out_valid <= 1'b0;
         bus.data_out  <= '0;
         bus.ovf       <= 1'b0;
         acc           <= '0;
      end else begin
         bus.out_valid <= valid_s1;
         if (valid_s1) begin
            bus.data_out <= result;
            bus.ovf      <= sat;
            if (mode_s1) begin
               acc <= result;
            end
         end
      end
   end

endmodule

// File: tb/tb_mac_pipeline.sv
// Scoreboard bench for mac_pipeline: an unsigned and a signed instance share
// clock and reset; expected results are queued at issue and popped on OUT_VALID.
module tb_mac_pipeline;

   localparam int W  = 8;
   localparam int OW = 20;

   logic clk = 1'b0;
   logic rst;
   int   cyc = 0;

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   mac_pipeline_if #(.WIDTH(W), .OUT_WIDTH(OW)) bus_u ();
   mac_pipeline_if #(.WIDTH(W), .OUT_WIDTH(OW)) bus_s ();

   mac_pipeline #(.WIDTH(W), .OUT_WIDTH(OW), .SIGNED(0)) dut_u (
      .clk(clk), .rst(rst), .bus(bus_u)
   );
   mac_pipeline #(.WIDTH(W), .OUT_WIDTH(OW), .SIGNED(1)) dut_s (
      .clk(clk), .rst(rst), .bus(bus_s)
   );

   typedef struct {
      logic [OW-1:0] data;
      logic          ovf;
      int            cyc;
      string         name;
   } exp_t;

   exp_t q_u[$];
   exp_t q_s[$];
   int   total = 0;
   int   bad   = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0d, want %0d (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic set_idle();
      bus_u.in_valid = 1'b0; bus_u.mode = 1'b0; bus_u.clr_acc = 1'b0;
      bus_u.a = '0; bus_u.b = '0; bus_u.c = '0;
      bus_s.in_valid = 1'b0; bus_s.mode = 1'b0; bus_s.clr_acc = 1'b0;
      bus_s.a = '0; bus_s.b = '0; bus_s.c = '0;
   endtask

   task automatic idle();
      @(posedge clk); #1;
      set_idle();
   endtask

   // sel=0 drives the unsigned instance, sel=1 the signed one.
   task automatic issue(input bit sel, input bit mode, input bit clr,
                        input logic [W-1:0] a, input logic [W-1:0] b, input logic [W-1:0] c,
                        input logic [OW-1:0] d, input bit ovf, input string name,
                        input bit push = 1'b1);
      exp_t e;
      @(posedge clk); #1;
      set_idle();
      if (!sel) begin
         bus_u.in_valid = 1'b1; bus_u.mode = mode; bus_u.clr_acc = clr;
         bus_u.a = a; bus_u.b = b; bus_u.c = c;
      end else begin
         bus_s.in_valid = 1'b1; bus_s.mode = mode; bus_s.clr_acc = clr;
         bus_s.a = a; bus_s.b = b; bus_s.c = c;
      end
      e.data = d; e.ovf = ovf; e.cyc = cyc + 2; e.name = name;
      if (push) begin
         if (!sel) q_u.push_back(e);
         else      q_s.push_back(e);
      end
   endtask

   always @(negedge clk) begin
      exp_t e;
      if (bus_u.out_valid === 1'b1) begin
         if (q_u.size() == 0) begin
            total++; bad++;
            $display("FAIL unexpected_u: got out_valid=1 data=%0d, want no output", bus_u.data_out);
         end else begin
            e = q_u.pop_front();
            check({e.name, "_data"}, 32'(bus_u.data_out), 32'(e.data));
            check({e.name, "_ovf"},  32'(bus_u.ovf),      32'(e.ovf));
            check({e.name, "_lat"},  32'(cyc),            32'(e.cyc));
         end
      end
      if (bus_s.out_valid === 1'b1) begin
         if (q_s.size() == 0) begin
            total++; bad++;
            $display("FAIL unexpected_s: got out_valid=1 data=%0d, want no output", bus_s.data_out);
         end else begin
            e = q_s.pop_front();
            check({e.name, "_data"}, 32'(bus_s.data_out), 32'(e.data));
            check({e.name, "_ovf"},  32'(bus_s.ovf),      32'(e.ovf));
            check({e.name, "_lat"},  32'(cyc),            32'(e.cyc));
         end
      end
   end

   initial begin
      logic [OW-1:0] d;
      int            tmp;
      set_idle();
      rst = 1'b1;
      repeat (2) @(posedge clk);
      #1 rst = 1'b0;
      @(negedge clk);
      check("rst_u_valid", 32'(bus_u.out_valid), 32'd0);
      check("rst_u_data",  32'(bus_u.data_out),  32'd0);
      check("rst_u_ovf",   32'(bus_u.ovf),       32'd0);
      check("rst_s_valid", 32'(bus_s.out_valid), 32'd0);
      check("rst_s_data",  32'(bus_s.data_out),  32'd0);
      check("rst_s_ovf",   32'(bus_s.ovf),       32'd0);

      // Unsigned multiply-add, back to back.
      issue(0, 0, 0, 8'd255, 8'd255, 8'd255, 20'd65280, 0, "madd0");
      issue(0, 0, 0, 8'd3,   8'd4,   8'd5,   20'd17,    0, "madd1");
      idle();

      // Unsigned accumulate up to and past the top bound.
      for (int k = 1; k <= 18; k++) begin
         d = (k <= 16) ? 20'(k * 65280) : 20'd1048575;
         issue(0, 1, (k == 1), 8'd255, 8'd255, 8'd255, d, (k > 16), $sformatf("uacc%0d", k));
      end
      idle();

      // Signed multiply-add.
      issue(1, 0, 0, 8'h80, 8'h80, 8'h80, 20'd16256,  0, "smadd0");
      issue(1, 0, 0, 8'h80, 8'h7f, 8'hff, 20'hFC07F,  0, "smadd1");

      // Signed accumulate: sample 32 lands exactly on the lower bound.
      for (int k = 1; k <= 34; k++) begin
         tmp = -16384 * k;
         d = (k <= 32) ? tmp[OW-1:0] : 20'h80000;
         issue(1, 1, (k == 1), 8'h80, 8'h7f, 8'h80, d, (k > 32), $sformatf("sacc%0d", k));
      end
      idle();

      // Interleaved modes and clear.
      issue(0, 1, 1, 8'd2,  8'd3,  8'd0, 20'd6,   0, "mix0");
      issue(0, 0, 0, 8'd10, 8'd10, 8'd1, 20'd101, 0, "mix1");
      issue(0, 1, 0, 8'd1,  8'd1,  8'd0, 20'd7,   0, "mix2");
      issue(0, 1, 1, 8'd4,  8'd4,  8'd0, 20'd16,  0, "mix3");
      idle();

      // Bubbles: valid pattern 1,0,0,1 with the first result held.
      issue(0, 0, 0, 8'd2, 8'd2, 8'd1, 20'd5, 0, "bub0");
      idle();
      idle();
      issue(0, 0, 0, 8'd1, 8'd1, 8'd1, 20'd2, 0, "bub1");
      @(negedge clk);
      check("bub_gap1_valid", 32'(bus_u.out_valid), 32'd0);
      check("bub_gap1_data",  32'(bus_u.data_out),  32'd5);
      idle();
      @(negedge clk);
      check("bub_gap2_valid", 32'(bus_u.out_valid), 32'd0);
      check("bub_gap2_data",  32'(bus_u.data_out),  32'd5);

      // Reset with two samples in flight.
      issue(0, 1, 1, 8'd20, 8'd25, 8'd0, 20'd500, 0, "pre_rst");
      repeat (3) idle();
      issue(0, 1, 0, 8'd1, 8'd1, 8'd0, 20'd501, 0, "flush0", 1'b0);
      issue(0, 1, 0, 8'd1, 8'd1, 8'd0, 20'd502, 0, "flush1", 1'b0);
      rst = 1'b1;
      @(negedge clk);
      check("flush_slot0_valid", 32'(bus_u.out_valid), 32'd0);
      @(posedge clk); #1;
      rst = 1'b0;
      set_idle();
      @(negedge clk);
      check("post_rst_valid", 32'(bus_u.out_valid), 32'd0);
      check("post_rst_data",  32'(bus_u.data_out),  32'd0);
      check("post_rst_ovf",   32'(bus_u.ovf),       32'd0);
      idle();
      @(negedge clk);
      check("flush_slot2_valid", 32'(bus_u.out_valid), 32'd0);
      issue(0, 1, 0, 8'd1, 8'd1, 8'd0, 20'd1, 0, "acc_cleared");
      idle();

      for (int i = 0; i < 20 && (q_u.size() != 0 || q_s.size() != 0); i++) @(negedge clk);
      total++;
      if (q_u.size() != 0 || q_s.size() != 0) begin
         bad++;
         $display("FAIL drain: got %0d/%0d results outstanding, want 0/0", q_u.size(), q_s.size());
      end
      @(negedge clk);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
